// File: rtl/counter_pkg.sv
// Shared defaults and parameter legality check for the modulo counter.
package counter_pkg;

    localparam int unsigned DefWidth   = 4;
    localparam int unsigned DefModulo  = 16;
    localparam int unsigned DefRstVal  = 0;
    localparam int unsigned SyncStages = 2;

    // True when modulo fits in width bits, is at least 2, and rst_val lies inside the count range.
    function automatic bit params_ok(int unsigned width, int unsigned modulo,
                                     int unsigned rst_val);
        longint unsigned span;
        longint unsigned mod_l;
        span  = 64'd1 << width;
        mod_l = 64'(modulo);
        return (modulo >= 2) && (mod_l <= span) && (rst_val < modulo);
    endfunction

endpackage

// File: rtl/reset_sync.sv
// Active-low reset synchronizer: asserts asynchronously, deasserts after Stages clock edges.
module reset_sync
    import counter_pkg::*;
#(
    parameter int unsigned Stages = SyncStages
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic rst_no
);

    generate
        if (Stages < 2) begin : g_bad_stages
            $error("reset_sync: Stages must be at least 2");
        end
    endgenerate

    logic [Stages-1:0] sync_q;

    // Shift ones in after release; any low level on rst_ni clears the chain at once.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[Stages-2:0], 1'b1};
        end
    end

    assign rst_no = sync_q[Stages-1];

endmodule

// File: rtl/counter_4bit.sv
// Free-running modulo counter with terminal-count flag and synchronized reset release.
module counter_4bit
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH   = DefWidth,
    parameter int unsigned MODULO  = DefModulo,
    parameter int unsigned RST_VAL = DefRstVal
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] q,
    output logic             tc
);

    generate
        if (!params_ok(WIDTH, MODULO, RST_VAL)) begin : g_bad_params
            $error("counter_4bit: need 2 <= MODULO <= 2**WIDTH and RST_VAL < MODULO");
        end
    endgenerate

    localparam logic [WIDTH-1:0] QMax = WIDTH'(MODULO - 1);
    localparam logic [WIDTH-1:0] QRst = WIDTH'(RST_VAL);

    logic             rst_sync_n;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    // rst asserts the counter reset immediately; release reaches it two edges later.
    reset_sync #(
        .Stages (SyncStages)
    ) u_reset_sync (
        .clk_i  (clk),
        .rst_ni (rst),
        .rst_no (rst_sync_n)
    );

    // Next count: wrap to zero at the terminal value, otherwise add one.
    always_comb begin
        q_d = q_q + WIDTH'(1);
        if (q_q == QMax) begin
            q_d = '0;
        end
    end

    // Count register; held at the restart value while the synchronized reset is low.
    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            q_q <= QRst;
        end else begin
            q_q <= q_d;
        end
    end

    assign q  = q_q;
    assign tc = (q_q == QMax);

endmodule

// File: tb/tb_counter_4bit.sv
// Scoreboard bench: the stimulus process queues hand-computed counts per cycle,
// the monitor pops and compares them on each falling clock edge.
module tb_counter_4bit;

    localparam int NSteps = 61;

    typedef struct {
        int         step;
        logic [3:0] qa;
        logic       tca;
        logic [3:0] qb;
        logic       tcb;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [3:0] q_a;
    logic       tc_a;
    logic [3:0] q_b;
    logic       tc_b;

    exp_t sb[$];
    int   n_checks;
    int   n_pass;

    // rst level driven at posedge+2 of each step (checked at that step's negedge).
    int rst_v [NSteps] = '{
        0, 0, 0,
        1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1,
        1, 1, 1, 1, 1, 1,
        0, 0,
        1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1,
        0, 0, 0,
        1, 1, 1, 1, 1,
        1, 1, 1
    };

    // Action in the half-cycle before a step: 1 = 1 ns low pulse, 2 = drop rst low and keep it.
    int pre_v [NSteps] = '{
        0, 0, 0,
        0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
        0, 0, 0, 0, 0, 0,
        0, 0,
        0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
        2, 0, 0,
        0, 0, 0, 0, 0,
        1, 0, 0
    };

    // Default instance: modulo 16, restart value 0.
    int qa_v [NSteps] = '{
        0, 0, 0,
        0, 0, 0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 0, 1, 2,
        3, 4, 5, 6, 7, 8,
        0, 0,
        0, 0, 0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15,
        0, 0, 0,
        0, 0, 0, 1, 2,
        0, 0, 1
    };

    // Second instance: modulo 10, restart value 3.
    int qb_v [NSteps] = '{
        3, 3, 3,
        3, 3, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1,
        2, 3, 4, 5, 6, 7,
        3, 3,
        3, 3, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2, 3, 4, 5, 6, 7, 8,
        3, 3, 3,
        3, 3, 3, 4, 5,
        3, 3, 4
    };

    counter_4bit u_dut_a (
        .clk (clk),
        .rst (rst),
        .q   (q_a),
        .tc  (tc_a)
    );

    counter_4bit #(
        .WIDTH   (4),
        .MODULO  (10),
        .RST_VAL (3)
    ) u_dut_b (
        .clk (clk),
        .rst (rst),
        .q   (q_b),
        .tc  (tc_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int step, input int act, input int exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s step %0d: got %0d, expected %0d", name, step, act, exp);
        end
    endtask

    // Monitor: compare the DUT outputs against the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("q_a", e.step, int'(q_a), int'(e.qa));
                chk("tc_a", e.step, int'(tc_a), int'(e.tca));
                chk("q_b", e.step, int'(q_b), int'(e.qb));
                chk("tc_b", e.step, int'(tc_b), int'(e.tcb));
            end
        end
    end

    // Stimulus: drive rst per step and queue the expected outputs for that cycle.
    initial begin
        exp_t e;
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b0;
        for (int s = 0; s < NSteps; s++) begin
            if (pre_v[s] == 1) begin
                @(negedge clk);
                #1 rst = 1'b0;
                #1 rst = 1'b1;
            end else if (pre_v[s] == 2) begin
                @(negedge clk);
                #1 rst = 1'b0;
            end
            @(posedge clk);
            #2;
            rst    = (rst_v[s] != 0);
            e.step = s;
            e.qa   = 4'(qa_v[s]);
            e.tca  = (qa_v[s] == 15);
            e.qb   = 4'(qb_v[s]);
            e.tcb  = (qb_v[s] == 9);
            sb.push_back(e);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (sb.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL drain: got %0d pending entries, expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
